// File: rtl/csr_exec_unit.sv
// Zicsr read-modify-write sequencer (IDLE -> EXEC -> RESP) in front of a CSR register file.
// Optional macro CSR_ILLEGAL_CHECK_EN adds address legality and read-only write checks.
module csr_exec_unit #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [4:0]        in_rs1,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [4:0]        in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_data,
  output logic              out_illegal,
  output logic [ADDR_W-1:0] csr_raddr,
  output logic              csr_ren,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic [ADDR_W-1:0] csr_waddr,
  output logic              csr_wen,
  output logic [XLEN-1:0]   csr_wdata,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid && ready at the rising edge;
  // in_ready depends only on state, and out_valid/out_rd/out_data hold until out_ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        rs1_q;
  logic [XLEN-1:0]   rs1_val_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   data_q;
  logic              illegal_q;

  logic              reserved, op_rw, op_rs, writes, illegal;
  logic [XLEN-1:0]   src, new_val;

  always_comb begin
    reserved = (f3_q[1:0] == 2'b00);
    op_rw    = (f3_q[1:0] == 2'b01);
    op_rs    = (f3_q[1:0] == 2'b10);
    src      = f3_q[2] ? {{(XLEN-5){1'b0}}, rs1_q} : rs1_val_q;
    // Set/clear with a zero source field are pure reads and must not touch the file.
    writes   = !reserved && (op_rw || (rs1_q != 5'd0));
    if (op_rw)      new_val = src;
    else if (op_rs) new_val = csr_rdata | src;
    else            new_val = csr_rdata & ~src;
  end

`ifdef CSR_ILLEGAL_CHECK_EN
  logic known_addr;

  always_comb begin
    case (addr_q)
      ADDR_W'(12'h300), ADDR_W'(12'h305), ADDR_W'(12'h344), ADDR_W'(12'h304),
      ADDR_W'(12'h340), ADDR_W'(12'h341), ADDR_W'(12'h342), ADDR_W'(12'h343),
      ADDR_W'(12'hB00), ADDR_W'(12'h180), ADDR_W'(12'hF14): known_addr = 1'b1;
      default: known_addr = 1'b0;
    endcase
  end

  // Top address bits 11 mark read-only CSRs; only an actual write is illegal there.
  assign illegal = reserved | ~known_addr | ((addr_q[ADDR_W-1 -: 2] == 2'b11) & writes);
`else
  assign illegal = reserved;
`endif

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    csr_raddr = '0;
    csr_ren   = 1'b0;
    csr_waddr = '0;
    csr_wen   = 1'b0;
    csr_wdata = '0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (!flush && in_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        csr_raddr = addr_q;
        csr_ren   = !(op_rw && (rd_q == 5'd0));
        if (!flush && !illegal && writes) begin
          csr_wen   = 1'b1;
          csr_waddr = addr_q;
          csr_wdata = new_val;
        end
        state_d = flush ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (flush || out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      f3_q      <= '0;
      addr_q    <= '0;
      rs1_q     <= '0;
      rs1_val_q <= '0;
      rd_q      <= '0;
      data_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && in_valid && !flush) begin
        f3_q      <= in_funct3;
        addr_q    <= in_addr;
        rs1_q     <= in_rs1;
        rs1_val_q <= in_rs1_val;
        rd_q      <= in_rd;
      end
      if (state_q == S_EXEC && !flush) begin
        data_q    <= illegal ? '0 : csr_rdata;
        illegal_q <= illegal;
      end
    end
  end

  assign out_rd      = rd_q;
  assign out_data    = data_q;
  assign out_illegal = illegal_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Self-checking bench for csr_exec_unit: directed Zicsr ops against a transaction-level CSR model.
// Builds with or without CSR_ILLEGAL_CHECK_EN; expectations follow the macro.
module tb_csr_exec_unit;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic              in_ready, out_valid, out_illegal, csr_ren, csr_wen;
  logic [2:0]        in_funct3;
  logic [ADDR_W-1:0] in_addr, csr_raddr, csr_waddr;
  logic [4:0]        in_rs1, in_rd, out_rd;
  logic [XLEN-1:0]   in_rs1_val, out_data, csr_rdata, csr_wdata;
  logic [1:0]        dbg_state;

  csr_exec_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3), .in_addr(in_addr),
    .in_rs1(in_rs1), .in_rs1_val(in_rs1_val), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
    .out_illegal(out_illegal), .csr_raddr(csr_raddr), .csr_ren(csr_ren), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_wen(csr_wen), .csr_wdata(csr_wdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- CSR file the DUT talks to ----------------
  logic [11:0] pre_addr [9] = '{12'h340, 12'h300, 12'h305, 12'h341, 12'h342,
                                12'h343, 12'hF14, 12'h7C0, 12'h344};
  logic [63:0] pre_val  [9] = '{64'h5, 64'h1880, 64'hFF, 64'h1234, 64'hAA,
                                64'hBB, 64'h3, 64'h77, 64'h10};
  bit   [63:0] file_mem [4096];
  logic        file_init = 1'b0;

  always_comb csr_rdata = csr_ren ? file_mem[csr_raddr] : '0;

  always @(posedge clk) begin
    if (file_init) begin
      for (int i = 0; i < 9; i++) file_mem[pre_addr[i]] <= pre_val[i];
    end else if (csr_wen) begin
      file_mem[csr_waddr] <= csr_wdata;
    end
  end

  // ---------------- model + scoreboard ----------------
  bit   [63:0] ref_mem [4096];
  logic [75:0] wr_q  [$];   // {addr, data}
  logic [69:0] rsp_q [$];   // {rd, data, illegal}
  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic [63:0] last_wdata, last_out;
  logic [4:0]  last_rd;
  logic        last_ill;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit known_csr(input logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h344, 12'h304, 12'h340, 12'h341,
                     12'h342, 12'h343, 12'hB00, 12'h180, 12'hF14};
  endfunction

  // Single compare process: every write strobe and every accepted response is checked.
  always @(negedge clk) begin
    if (!reset) begin
      if (csr_wen) begin
        n_writes++;
        if (wr_q.size() == 0) begin
          check("unexpected_write", {52'd0, csr_waddr}, 64'hFFFF_FFFF);
        end else begin
          logic [75:0] w;
          w = wr_q.pop_front();
          check("wr_addr", {52'd0, csr_waddr}, {52'd0, w[75:64]});
          check("wr_data", csr_wdata, w[63:0]);
          last_wdata = csr_wdata;
        end
      end
      if (out_valid && out_ready && !flush) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_resp", {59'd0, out_rd}, 64'hFFFF_FFFF);
        end else begin
          logic [69:0] r;
          r = rsp_q.pop_front();
          check("rsp_rd", {59'd0, out_rd}, {59'd0, r[69:65]});
          check("rsp_data", out_data, r[64:1]);
          check("rsp_illegal", {63'd0, out_illegal}, {63'd0, r[0]});
          last_out = out_data;
          last_rd  = out_rd;
          last_ill = out_illegal;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 normal, 1 flush in EXEC, 2 reset in RESP, 3 flush in RESP
  task automatic run_op(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                        input logic [63:0] rs1v, input logic [4:0] rd, input int hold,
                        input int mode);
    logic [63:0] old, src, nv, held;
    bit rsv, rw, rs, wr, ill, ren_e;
    old   = ref_mem[addr];
    rsv   = (f3[1:0] == 2'b00);
    rw    = (f3[1:0] == 2'b01);
    rs    = (f3[1:0] == 2'b10);
    src   = f3[2] ? {59'd0, rs1} : rs1v;
    wr    = !rsv && (rw || rs1 != 5'd0);
    ill   = rsv;
`ifdef CSR_ILLEGAL_CHECK_EN
    ill   = ill || !known_csr(addr) || (addr[11:10] == 2'b11 && wr);
`endif
    ren_e = !(rw && rd == 5'd0);
    nv    = rw ? src : (rs ? (old | src) : (old & ~src));
    if (wr && !ill && mode != 1) begin
      wr_q.push_back({addr, nv});
      ref_mem[addr] = nv;
    end
    if (mode == 0) rsp_q.push_back({rd, (ill || !ren_e) ? 64'd0 : old, ill});

    in_valid = 1'b1; in_funct3 = f3; in_addr = addr; in_rs1 = rs1; in_rs1_val = rs1v; in_rd = rd;
    step();
    in_valid  = 1'b0;
    out_ready = (mode == 0 && hold == 0);
    flush     = (mode == 1);
    @(negedge clk);
    check("exec_ren", {63'd0, csr_ren}, {63'd0, ren_e});
    check("exec_raddr", {52'd0, csr_raddr}, {52'd0, addr});
    check("exec_no_valid", {63'd0, out_valid}, 64'd0);
    step();
    flush = 1'b0;
    if (mode == 1) begin
      @(negedge clk);
      check("flush_exec_ready", {63'd0, in_ready}, 64'd1);
      check("flush_exec_valid", {63'd0, out_valid}, 64'd0);
      return;
    end
    @(negedge clk);
    check("resp_valid", {63'd0, out_valid}, 64'd1);
    check("resp_not_ready", {63'd0, in_ready}, 64'd0);
    held = out_data;
    if (mode == 2 || mode == 3) begin
      #1;
      if (mode == 2) reset = 1'b1; else flush = 1'b1;
      step();
      reset = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("abort_valid", {63'd0, out_valid}, 64'd0);
      check("abort_ready", {63'd0, in_ready}, 64'd1);
      if (mode == 2) check("reset_data", out_data, 64'd0);
      return;
    end
    if (hold > 0) begin
      repeat (hold) begin
        step();
        @(negedge clk);
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_data", out_data, held);
        check("hold_ready", {63'd0, in_ready}, 64'd0);
      end
      step();
      out_ready = 1'b1;
      @(negedge clk);
    end
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("idle_valid", {63'd0, out_valid}, 64'd0);
    check("idle_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct3 = '0; in_addr = '0; in_rs1 = '0; in_rs1_val = '0; in_rd = '0;
    for (int i = 0; i < 9; i++) ref_mem[pre_addr[i]] = pre_val[i];
    file_init = 1'b1;
    repeat (3) step();
    file_init = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_csr_wen", {63'd0, csr_wen}, 64'd0);
    check("rst_csr_ren", {63'd0, csr_ren}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_rd", {59'd0, out_rd}, 64'd0);
    check("rst_out_illegal", {63'd0, out_illegal}, 64'd0);

    run_op(3'b001, 12'h340, 5'd1, 64'hDEAD, 5'd5, 0, 0);       // CSRRW mscratch
    check("lit_rw_wdata", last_wdata, 64'hDEAD);
    check("lit_rw_old", last_out, 64'h5);
    check("lit_rw_rd", {59'd0, last_rd}, 64'd5);
    run_op(3'b010, 12'h300, 5'd0, 64'hFFFF, 5'd6, 0, 0);       // CSRRS x0: read only
    check("lit_rs_x0_nowrite", n_writes, 64'd1);
    check("lit_rs_x0_old", last_out, 64'h1880);
    run_op(3'b110, 12'h300, 5'd8, 64'd0, 5'd7, 0, 0);          // CSRRSI zimm=8
    check("lit_rsi_wdata", last_wdata, 64'h1888);
    run_op(3'b011, 12'h305, 5'd2, 64'h0F, 5'd8, 0, 0);         // CSRRC
    check("lit_rc_wdata", last_wdata, 64'hF0);
    check("lit_rc_old", last_out, 64'hFF);
    run_op(3'b111, 12'h305, 5'd0, 64'hFF, 5'd9, 0, 0);         // CSRRCI zimm=0
    check("lit_rci0_nowrite", n_writes, 64'd3);
    check("lit_rci0_old", last_out, 64'hF0);
    run_op(3'b001, 12'h344, 5'd3, 64'h22, 5'd0, 0, 0);         // CSRRW rd=x0
    check("lit_rw_rd0_wdata", last_wdata, 64'h22);
    run_op(3'b010, 12'h341, 5'd4, 64'h1, 5'd11, 5, 0);         // back-pressure
    check("lit_hold_wdata", last_wdata, 64'h1235);
    check("lit_hold_old", last_out, 64'h1234);
    run_op(3'b001, 12'h342, 5'd1, 64'h77, 5'd12, 0, 1);        // flush in EXEC
    check("lit_flush_exec_nowrite", n_writes, 64'd5);
    check("lit_flush_exec_file", file_mem[12'h342], 64'hAA);
    run_op(3'b001, 12'h343, 5'd1, 64'h99, 5'd13, 0, 2);        // reset in RESP
    check("lit_reset_resp_file", file_mem[12'h343], 64'h99);
    run_op(3'b010, 12'h300, 5'd5, 64'h1, 5'd14, 0, 3);         // flush in RESP
    check("lit_flush_resp_file", file_mem[12'h300], 64'h1889);
    run_op(3'b000, 12'h340, 5'd1, 64'h1, 5'd15, 0, 0);         // reserved funct3
    check("lit_rsv0_ill", {63'd0, last_ill}, 64'd1);
    check("lit_rsv0_data", last_out, 64'd0);
    run_op(3'b100, 12'h340, 5'd1, 64'h1, 5'd16, 0, 0);
    check("lit_rsv4_ill", {63'd0, last_ill}, 64'd1);
    check("lit_rsv_nowrite", file_mem[12'h340], 64'hDEAD);

    run_op(3'b001, 12'hF14, 5'd1, 64'h55, 5'd17, 0, 0);        // write mhartid
`ifdef CSR_ILLEGAL_CHECK_EN
    check("lit_mhartid_w_ill", {63'd0, last_ill}, 64'd1);
    check("lit_mhartid_w_data", last_out, 64'd0);
`else
    check("lit_mhartid_w_ill", {63'd0, last_ill}, 64'd0);
    check("lit_mhartid_w_data", last_out, 64'd3);
`endif
    run_op(3'b010, 12'hF14, 5'd0, 64'h0, 5'd18, 0, 0);         // read mhartid
    check("lit_mhartid_r_ill", {63'd0, last_ill}, 64'd0);
`ifdef CSR_ILLEGAL_CHECK_EN
    check("lit_mhartid_r_data", last_out, 64'd3);
`else
    check("lit_mhartid_r_data", last_out, 64'h55);
`endif
    run_op(3'b001, 12'h7C0, 5'd1, 64'h1, 5'd19, 0, 0);         // unknown custom CSR
`ifdef CSR_ILLEGAL_CHECK_EN
    check("lit_7c0_ill", {63'd0, last_ill}, 64'd1);
`else
    check("lit_7c0_ill", {63'd0, last_ill}, 64'd0);
    check("lit_7c0_old", last_out, 64'h77);
`endif

    // flush while presenting an op in IDLE: op is dropped
    in_valid = 1'b1; in_funct3 = 3'b001; in_addr = 12'h340; in_rs1 = 5'd1;
    in_rs1_val = 64'h1; in_rd = 5'd20; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_ready", {63'd0, in_ready}, 64'd1);
    check("flush_idle_ren", {63'd0, csr_ren}, 64'd0);
    step();
    @(negedge clk);
    check("flush_idle_valid", {63'd0, out_valid}, 64'd0);

    // back-to-back ops at full throughput
    for (int i = 0; i < 4; i++) begin
      run_op(3'b001 + 3'(i % 3), 12'h340, 5'(i + 1), 64'(32'h1111 * (i + 1)), 5'(21 + i), 0, 0);
    end

    step();
    check("wr_q_drained", wr_q.size(), 64'd0);
    check("rsp_q_drained", rsp_q.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
